// File: rtl/control_sequencer.sv
// Hardwired T-state control unit for the 32-bit register-file CPU.
// Moore sequencer with a memory ready/strobe handshake and a sticky timeout fault.
module control_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TO_W        = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        pc_out,
  output logic        mar_in,
  output logic        inc_pc,
  output logic        pc_in,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        ir_in,
  output logic        read,
  output logic        write,
  output logic        y_in,
  output logic        z_in,
  output logic        zlow_out,
  output logic        c_out,
  output logic [3:0]  alu_op,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        r_in,
  output logic        r_out,
  output logic        ba_out,
  output logic        run,
  output logic        fault
);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // S_RST is the reset-held T0: all strobes quiet until the first edge after release.
  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              fault_q, fault_d;

  logic [4:0] op_c;
  logic       is_alu_c, is_imm_c, is_mem_c, is_ld_c, is_st_c;
  logic       wait_c, timeout_c;
  logic       unused_ir;

  assign op_c      = ir[31:27];
  assign unused_ir = ^ir[26:0];
  assign is_ld_c   = (op_c == OP_LD);
  assign is_st_c   = (op_c == OP_ST);
  assign is_mem_c  = is_ld_c | is_st_c;
  assign is_imm_c  = is_mem_c | (op_c == OP_ADDI);
  assign is_alu_c  = (op_c == OP_ADD) | (op_c == OP_SUB) |
                     (op_c == OP_AND) | (op_c == OP_OR);

  assign wait_c    = (state_q == S_T1) |
                     ((state_q == S_T6) & is_ld_c) |
                     ((state_q == S_T7) & is_st_c);
  // The handshake wins over the timeout when mem_ready arrives on the last allowed cycle.
  assign timeout_c = wait_c & ~mem_ready & (cnt_q == TO_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RST;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (wait_c && !mem_ready) ? cnt_q + TO_W'(1) : '0;
    fault_d = fault_q | timeout_c;
    unique case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (mem_ready) state_d = S_T2;
              else if (timeout_c) state_d = S_HALT;
      S_T2:   state_d = S_T3;
      S_T3:   if (is_alu_c || is_imm_c) state_d = S_T4;
              else if (op_c == OP_HALT) state_d = S_HALT;
              else state_d = S_T0;
      S_T4:   state_d = S_T5;
      S_T5:   state_d = is_mem_c ? S_T6 : S_T0;
      S_T6:   if (!is_ld_c || mem_ready) state_d = S_T7;
              else if (timeout_c) state_d = S_HALT;
      S_T7:   if (!is_st_c || mem_ready) state_d = S_T0;
              else if (timeout_c) state_d = S_HALT;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  always_comb begin
    pc_out = 1'b0; mar_in = 1'b0; inc_pc = 1'b0; pc_in = 1'b0;
    mdr_in = 1'b0; mdr_out = 1'b0; ir_in = 1'b0; read = 1'b0; write = 1'b0;
    y_in = 1'b0; z_in = 1'b0; zlow_out = 1'b0; c_out = 1'b0; alu_op = 4'b0000;
    gra = 1'b0; grb = 1'b0; grc = 1'b0; r_in = 1'b0; r_out = 1'b0; ba_out = 1'b0;
    run   = (state_q != S_HALT);
    fault = fault_q;
    unique case (state_q)
      S_T0: begin pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1; end
      S_T1: begin zlow_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1; end
      S_T2: begin mdr_out = 1'b1; ir_in = 1'b1; end
      S_T3: begin
        if (is_alu_c) begin grb = 1'b1; r_out = 1'b1; y_in = 1'b1; end
        else if (is_imm_c) begin grb = 1'b1; ba_out = 1'b1; y_in = 1'b1; end
      end
      S_T4: begin
        z_in = 1'b1;
        if (is_alu_c) begin
          grc = 1'b1; r_out = 1'b1;
          unique case (op_c)
            OP_SUB:  alu_op = 4'b0001;
            OP_AND:  alu_op = 4'b0010;
            OP_OR:   alu_op = 4'b0011;
            default: alu_op = 4'b0000;
          endcase
        end else begin
          c_out = 1'b1;
        end
      end
      S_T5: begin
        zlow_out = 1'b1;
        if (is_mem_c) mar_in = 1'b1;
        else begin gra = 1'b1; r_in = 1'b1; end
      end
      S_T6: begin
        mdr_in = 1'b1;
        if (is_ld_c) read = 1'b1;
        else begin gra = 1'b1; r_out = 1'b1; end
      end
      S_T7: begin
        if (is_ld_c) begin mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
        else write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomised self-checking bench for control_sequencer: each instruction's per-cycle
// control word is rebuilt from the opcode's micro-step list and the mem_ready pattern.
module tb_control_sequencer;

  localparam int unsigned MEM_TIMEOUT = 16;
  localparam int unsigned TO_W        = 5;

  typedef struct packed {
    logic pc_out, mar_in, inc_pc, pc_in, mdr_in, mdr_out, ir_in, read, write;
    logic y_in, z_in, zlow_out, c_out;
    logic [3:0] alu_op;
    logic gra, grb, grc, r_in, r_out, ba_out, run, fault;
  } cw_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] ir = '0;
  logic        mem_ready = 1'b0;
  logic pc_out, mar_in, inc_pc, pc_in, mdr_in, mdr_out, ir_in, read, write;
  logic y_in, z_in, zlow_out, c_out, gra, grb, grc, r_in, r_out, ba_out, run, fault;
  logic [3:0] alu_op;
  cw_t obs;

  int nvec = 0;
  int nfail = 0;

  control_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .reset_n(reset_n), .ir(ir), .mem_ready(mem_ready),
    .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .pc_in(pc_in),
    .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .read(read), .write(write),
    .y_in(y_in), .z_in(z_in), .zlow_out(zlow_out), .c_out(c_out), .alu_op(alu_op),
    .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out), .ba_out(ba_out),
    .run(run), .fault(fault)
  );

  always #5 clk = ~clk;

  assign obs = {pc_out, mar_in, inc_pc, pc_in, mdr_in, mdr_out, ir_in, read, write,
                y_in, z_in, zlow_out, c_out, alu_op,
                gra, grb, grc, r_in, r_out, ba_out, run, fault};

  function automatic cw_t running();
    cw_t c = '0;
    c.run = 1'b1;
    return c;
  endfunction

  task automatic check(input string tag, input cw_t exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check the word held during this cycle, then present mem_ready for the coming edge.
  task automatic step(input string tag, input cw_t exp, input logic mr);
    @(negedge clk);
    check(tag, exp);
    mem_ready = mr;
  endtask

  task automatic wait_step(input string tag, input cw_t c, input int lat, output bit to);
    to = 1'b0;
    for (int k = 0; k < int'(MEM_TIMEOUT); k++) begin
      step(tag, c, k >= lat);
      if (k >= lat) return;
      if (k == int'(MEM_TIMEOUT) - 1) to = 1'b1;
    end
  endtask

  task automatic halt_steps(input string tag, input int n, input bit f);
    cw_t c = '0;
    c.fault = f;
    repeat (n) step(tag, c, 1'($urandom));
  endtask

  task automatic apply_reset();
    cw_t c = running();
    reset_n = 1'b0;
    #1 check("reset_async", c);
    @(negedge clk);
    check("reset_hold", c);
    reset_n = 1'b1;
    mem_ready = 1'b1;
  endtask

  task automatic do_instr(input logic [31:0] instr, input int lat1, input int lat2,
                          input bit abort_t4, output bit halted);
    cw_t c;
    bit to;
    bit alu, imm, ld, st, hlt;
    logic [4:0] op;
    halted = 1'b0;
    op  = instr[31:27];
    ld  = (op == 5'b00000);
    st  = (op == 5'b00010);
    alu = (op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110});
    imm = ld || st || (op == 5'b01100);
    hlt = (op == 5'b11011);

    c = running(); c.pc_out = 1; c.mar_in = 1; c.inc_pc = 1; c.z_in = 1;
    step("T0", c, 1'($urandom));
    ir = instr;
    c = running(); c.zlow_out = 1; c.pc_in = 1; c.read = 1; c.mdr_in = 1;
    wait_step("T1", c, lat1, to);
    if (to) begin halt_steps("fetch_timeout", 4, 1'b1); halted = 1'b1; return; end
    c = running(); c.mdr_out = 1; c.ir_in = 1;
    step("T2", c, 1'($urandom));

    c = running();
    if (alu) begin c.grb = 1; c.r_out = 1; c.y_in = 1; end
    else if (imm) begin c.grb = 1; c.ba_out = 1; c.y_in = 1; end
    step("T3", c, 1'($urandom));
    if (hlt) begin halt_steps("halt", 100, 1'b0); halted = 1'b1; return; end
    if (!alu && !imm) return;

    c = running(); c.z_in = 1;
    if (alu) begin
      c.grc = 1; c.r_out = 1;
      c.alu_op = (op == 5'b00100) ? 4'd1 : (op == 5'b00101) ? 4'd2 :
                 (op == 5'b00110) ? 4'd3 : 4'd0;
    end else c.c_out = 1;
    step("T4", c, 1'($urandom));
    if (abort_t4) begin apply_reset(); return; end

    c = running(); c.zlow_out = 1;
    if (ld || st) c.mar_in = 1; else begin c.gra = 1; c.r_in = 1; end
    step("T5", c, 1'($urandom));
    if (!ld && !st) return;

    if (ld) begin
      c = running(); c.read = 1; c.mdr_in = 1;
      wait_step("T6_ld", c, lat2, to);
      if (to) begin halt_steps("ld_timeout", 4, 1'b1); halted = 1'b1; return; end
      c = running(); c.mdr_out = 1; c.gra = 1; c.r_in = 1;
      step("T7_ld", c, 1'($urandom));
    end else begin
      c = running(); c.gra = 1; c.r_out = 1; c.mdr_in = 1;
      step("T6_st", c, 1'($urandom));
      c = running(); c.write = 1;
      wait_step("T7_st", c, lat2, to);
      if (to) begin halt_steps("st_timeout", 4, 1'b1); halted = 1'b1; return; end
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op);
    return {op, 27'($urandom)};
  endfunction

  initial begin
    bit h;
    logic [4:0] ops [9];
    ops = '{5'b00000, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
            5'b00110, 5'b01100, 5'b11010, 5'b10001};
    #2 apply_reset();

    do_instr(32'h18918000, 0, 0, 1'b0, h);
    do_instr(mk(5'b00011), 0, 0, 1'b1, h);
    do_instr(mk(5'b00000), 0, 3, 1'b0, h);

    for (int i = 0; i < 60; i++) begin
      logic [4:0] op;
      int l1, l2;
      op = ops[$urandom_range(0, 8)];
      if (op == 5'b10001) op = 5'($urandom);
      if (op == 5'b11011) op = 5'b11010;
      l1 = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
      l2 = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
      do_instr(mk(op), l1, l2, 1'b0, h);
      if (h) apply_reset();
    end

    do_instr(mk(5'b00101), 15, 0, 1'b0, h);
    do_instr(mk(5'b00000), 0, 15, 1'b0, h);
    do_instr(mk(5'b00010), 0, 16, 1'b0, h);
    if (h) apply_reset();
    do_instr(mk(5'b00000), 0, 20, 1'b0, h);
    if (h) apply_reset();
    do_instr(mk(5'b00110), 16, 0, 1'b0, h);
    if (h) apply_reset();

    do_instr(mk(5'b11111), 0, 0, 1'b0, h);
    do_instr(mk(5'b11011), 0, 0, 1'b0, h);
    apply_reset();
    do_instr(mk(5'b00100), 1, 0, 1'b0, h);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
